clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised successor to the single-channel 1 MHz counter-based divider.
- Generates CH independent divided clocks from one source clock.
- Per channel: enable, safe (boundary-aligned) divisor reload with shadow register, one-cycle tick pulse at each output edge, and reload-pending status.
- Sits between the 1 MHz system clock and timer, display and buzzer logic that need several slow rates at once.

Parameters:
- CH, 4, number of independent divider channels (1..16).
- DIV_W, 20, width of each divisor value.
- DEFAULT_DIV, 499999, reset value of the active and shadow divisors (1 MHz -> 1 Hz square wave).

Ports:
- clk  in  1  source clock (1 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  CH  per-channel enable, level-sensitive.
- load_i  in  CH  per-channel one-cycle strobe; captures that channel's div_i slice into its shadow register.
- div_i  in  CH*DIV_W  packed divisors; channel k uses bits [k*DIV_W +: DIV_W].
- clk_o  out  CH  divided clock outputs, registered.
- tick_o  out  CH  one-cycle pulse, high in the cycle clk_o[k] changes value.
- pend_o  out  CH  high while the shadow divisor is waiting to be applied.

Behaviour:
- Reset (rst_n low, async): all counters 0; active and shadow = DEFAULT_DIV; clk_o, tick_o, pend_o all 0.
- Per channel: registers cnt[DIV_W], act[DIV_W], shd[DIV_W]. Channels are fully independent; no cross-channel interaction.
- Counting, en_i[k]=1:
  - If cnt == act: next cnt = 0, clk_o toggles, tick_o = 1 in the same cycle as the new clk_o value.
  - Otherwise: cnt increments, clk_o holds, tick_o = 0.
- Output period:
  - Half period = act+1 cycles; full period = 2*(act+1).
  - act=0 gives clk/2 with tick_o high every cycle.
- Comparison is equality only. cnt can never exceed act, because act changes only when cnt is reset to 0.
- Load:
  - load_i[k]=1: shd <= div_i slice; pend_o[k] <= 1.
  - A repeated load while pending overwrites shd. Last write wins.
- Apply (enabled channel):
  - At a boundary cycle (cnt==act while enabled), if pend=1: act <= shd, pend <= 0.
  - The first half-period after the boundary uses the new value.
- Load coinciding with a boundary cycle:
  - The new value goes to shd and pend stays/becomes 1.
  - It is applied at the NEXT boundary. The previous shd, if one was pending, is applied at this boundary.
- Disabled (en_i[k]=0):
  - cnt <= 0, clk_o <= 0, tick_o <= 0.
  - If pend=1: act <= shd and pend <= 0 on the next cycle. This applies even if load_i is asserted in the same cycle; that case is handled as load-then-apply, so pend is re-set and act takes the new value one cycle later.
- Enable rising: counting starts from cnt=0. The first clk_o rising edge (0->1) comes act+1 cycles after the first enabled cycle.
- Enable falling mid-period: the output is forced low on the next clk edge. tick_o is not asserted for that forced transition.
- Reset asserted mid-operation: immediate return to reset values. Pending loads are discarded.

Optional Feature:
- Macro CLK_DIV_DUTY_EN.
- When defined:
  - Adds input hi_i [CH*DIV_W] and a per-channel shadow/active high-time register.
  - load_i captures hi_i together with div_i; both are applied atomically at the same boundary.
  - The compare target is act_hi while clk_o=1 and act while clk_o=0.
  - Period = (act_hi+1)+(act+1).
  - act_hi resets to DEFAULT_DIV.
- When undefined: no hi_i port; high and low times both equal act+1 (50% duty).

Decomposition:
- Package clk_div_pkg holds:
  - default constants for DIV_W and DEFAULT_DIV;
  - a typedef for the divisor word;
  - a localparam function computing DIV from source and target frequency, for use by integrators.
- One sub-module: clk_div_chan, a single channel containing cnt/act/shd/pend/clk_o/tick_o.
- The top generates CH instances and slices the packed buses.

Test Plan:
- Reset defaults: rst_n low, then release with en_i=0 -> clk_o=0, tick_o=0, pend_o=0. Enable ch0 -> first clk_o rise after 500000 cycles.
- Basic divide: load ch1 div=3 while disabled, then enable -> clk_o[1] period 8 cycles, 50% duty; tick_o[1] high every 4th cycle.
- Divide-by-2 edge: div=0 on ch2 -> clk_o[2] toggles every cycle; tick_o[2] constantly 1.
- Mid-run reload: ch0 running div=5; load div=1 at cnt=2 -> pend_o=1 until cnt reaches 5. The next half-periods are 2 cycles and pend_o returns to 0.
- Boundary collision: load div=9 in the exact cycle cnt==act on a channel already pending div=2 -> div=2 applied now, div=9 applied one half-period (3 cycles) later.
- Async reset mid-count (and CLK_DIV_DUTY_EN build with hi=1, div=3 -> high 2 cycles, low 4): assert rst_n low between clocks -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Integrators can use calc_div() in constant expressions to size divisors.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF       = 20;
  localparam int unsigned DEFAULT_DIV_DEF = 499999;

  typedef logic [DIV_W_DEF-1:0] div_word_t;

  // Half-period divisor for a square wave of f_out_hz from f_src_hz.
  // The divider toggles every (div+1) source cycles, so div = f_src/(2*f_out) - 1.
  function automatic div_word_t calc_div(input longint unsigned f_src_hz,
                                         input longint unsigned f_out_hz);
    longint unsigned half;
    if (f_out_hz == 0) return '0;
    half = f_src_hz / (2 * f_out_hz);
    return (half == 0) ? '0 : div_word_t'(half - 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag and tick.
// With CLK_DIV_DUTY_EN defined, a separate high-time divisor sets the duty cycle.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [DIV_W-1:0] hi,
`endif
  output logic             div_clk,
  output logic             tick,
  output logic             pend
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act;
  logic [DIV_W-1:0] shd;
  logic [DIV_W-1:0] tgt;
  logic             at_tgt;
  logic             apply;

`ifdef CLK_DIV_DUTY_EN
  logic [DIV_W-1:0] act_hi;
  logic [DIV_W-1:0] shd_hi;

  assign tgt = div_clk ? act_hi : act;
`else
  assign tgt = act;
`endif

  assign at_tgt = (cnt == tgt);
  // Shadow moves to active only when cnt restarts, so cnt never overshoots act.
  assign apply  = pend && (!en || at_tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (at_tgt) begin
      cnt     <= '0;
      div_clk <= ~div_clk;
      tick    <= 1'b1;
    end else begin
      cnt     <= cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act    <= RST_DIV;
      shd    <= RST_DIV;
      pend   <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      act_hi <= RST_DIV;
      shd_hi <= RST_DIV;
`endif
    end else begin
      if (apply) begin
        act    <= shd;
`ifdef CLK_DIV_DUTY_EN
        act_hi <= shd_hi;
`endif
      end
      // A load in the apply cycle lands in the shadow and waits for the next boundary.
      if (load) begin
        shd    <= div;
`ifdef CLK_DIV_DUTY_EN
        shd_hi <= hi;
`endif
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// CH independent clock dividers from one source clock, with safe divisor reload.
// Define CLK_DIV_DUTY_EN to add the hi_i high-time input for programmable duty cycle.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         en_i,
  input  logic [CH-1:0]         load_i,
  input  logic [CH*DIV_W-1:0]   div_i,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CH*DIV_W-1:0]   hi_i,
`endif
  output logic [CH-1:0]         clk_o,
  output logic [CH-1:0]         tick_o,
  output logic [CH-1:0]         pend_o
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_i[k]),
      .load    (load_i[k]),
      .div     (div_i[k*DIV_W +: DIV_W]),
`ifdef CLK_DIV_DUTY_EN
      .hi      (hi_i[k*DIV_W +: DIV_W]),
`endif
      .div_clk (clk_o[k]),
      .tick    (tick_o[k]),
      .pend    (pend_o[k])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi against a half-period countdown model.
// Also exercises the CLK_DIV_DUTY_EN build when that macro is defined.
module tb_clk_div_multi;

  localparam int CH          = 4;
  localparam int DIV_W       = 20;
  localparam int DEFAULT_DIV = 999;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH-1:0]       en_i = '0;
  logic [CH-1:0]       load_i = '0;
  logic [CH*DIV_W-1:0] div_i = '0;
`ifdef CLK_DIV_DUTY_EN
  logic [CH*DIV_W-1:0] hi_i = '0;
`endif
  logic [CH-1:0]       clk_o;
  logic [CH-1:0]       tick_o;
  logic [CH-1:0]       pend_o;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  // Reference model: each channel counts down the cycles left in its half-period.
  logic [CH-1:0] m_clk, m_tick, m_pend, m_fresh;
  int unsigned   m_act[CH], m_shd[CH], m_ha[CH], m_hs[CH], m_left[CH];

  always #5 clk = ~clk;

  clk_div_multi #(
    .CH          (CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .load_i (load_i),
    .div_i  (div_i),
`ifdef CLK_DIV_DUTY_EN
    .hi_i   (hi_i),
`endif
    .clk_o  (clk_o),
    .tick_o (tick_o),
    .pend_o (pend_o)
  );

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_act[k]  = DEFAULT_DIV;
      m_shd[k]  = DEFAULT_DIV;
      m_ha[k]   = DEFAULT_DIV;
      m_hs[k]   = DEFAULT_DIV;
      m_left[k] = 0;
    end
    m_clk = '0; m_tick = '0; m_pend = '0; m_fresh = '1;
  endtask

  function automatic int unsigned half_len(int k);
    return (m_clk[k] ? m_ha[k] : m_act[k]) + 1;
  endfunction

  task automatic model_step();
    for (int k = 0; k < CH; k++) begin
      int unsigned nd, nh;
      nd = div_i[k*DIV_W +: DIV_W];
`ifdef CLK_DIV_DUTY_EN
      nh = hi_i[k*DIV_W +: DIV_W];
`else
      nh = nd;
`endif
      if (en_i[k]) begin
        if (m_fresh[k]) begin
          m_left[k]  = half_len(k);
          m_fresh[k] = 1'b0;
        end
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_clk[k]  = ~m_clk[k];
          m_tick[k] = 1'b1;
          if (m_pend[k]) begin
            m_act[k] = m_shd[k]; m_ha[k] = m_hs[k]; m_pend[k] = 1'b0;
          end
          m_left[k] = half_len(k);
        end else begin
          m_tick[k] = 1'b0;
        end
      end else begin
        m_clk[k] = 1'b0; m_tick[k] = 1'b0; m_fresh[k] = 1'b1;
        if (m_pend[k]) begin
          m_act[k] = m_shd[k]; m_ha[k] = m_hs[k]; m_pend[k] = 1'b0;
        end
      end
      if (load_i[k]) begin
        m_shd[k] = nd; m_hs[k] = nh; m_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_load(int k, int unsigned d);
    load_i[k] = 1'b1;
    div_i[k*DIV_W +: DIV_W] = DIV_W'(d);
`ifdef CLK_DIV_DUTY_EN
    hi_i[k*DIV_W +: DIV_W] = DIV_W'(d);
`endif
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b0; en_i = '0; load_i = '0;
    model_reset();
    #3;
    n_tot++;
    if ({clk_o, tick_o, pend_o} !== '0)
      $display("FAIL reset_hold: clk/tick/pend got %b/%b/%b want all 0", clk_o, tick_o, pend_o);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL reset_idle: got %b/%b/%b want %b/%b/%b", clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
    end
    en_i[0] = 1'b1;
    first = 0;
    for (int i = 1; i <= 4000 && first == 0; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL reset_first_rise cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
      if (clk_o[0]) first = i;
    end
    n_tot++;
    if (first != DEFAULT_DIV + 1)
      $display("FAIL reset_rise_latency: got %0d cycles want %0d", first, DEFAULT_DIV + 1);
    else n_pass++;
  endtask

  task automatic test_basic_divide();
    int ticks, highs;
    set_load(1, 3); cycle(); load_i = '0;
    n_tot++;
    if (pend_o !== m_pend) $display("FAIL basic_pend: got %b want %b", pend_o, m_pend);
    else n_pass++;
    cycle();
    en_i[1] = 1'b1;
    ticks = 0; highs = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL basic_run cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
      ticks += int'(tick_o[1]);
      highs += int'(clk_o[1]);
    end
    n_tot++;
    if (ticks != 8) $display("FAIL basic_tick_count: got %0d want 8", ticks);
    else n_pass++;
    n_tot++;
    if (highs != 16) $display("FAIL basic_duty: got %0d high cycles want 16", highs);
    else n_pass++;
  endtask

  task automatic test_div2();
    set_load(2, 0); cycle(); load_i = '0;
    cycle();
    en_i[2] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL div2_run cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
      n_tot++;
      if (tick_o[2] !== 1'b1) $display("FAIL div2_tick cyc%0d: got %b want 1", i, tick_o[2]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reload();
    int n;
    logic got;
    en_i[0] = 1'b0; cycle();
    set_load(0, 5); cycle(); load_i = '0;
    cycle();
    en_i[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = tick_o[0];
    end
    n_tot++;
    if (!got) $display("FAIL reload_first_tick: got no tick want tick within 20 cycles");
    else n_pass++;
    cycle(); cycle();
    set_load(0, 1); cycle(); load_i = '0;
    n_tot++;
    if (pend_o[0] !== 1'b1) $display("FAIL reload_pend_set: got %b want 1", pend_o[0]);
    else n_pass++;
    n = 0;
    for (int i = 0; i < 20 && pend_o[0]; i++) begin
      cycle(); n++;
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL reload_wait cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
    end
    n_tot++;
    if (n != 3 || tick_o[0] !== 1'b1)
      $display("FAIL reload_apply: got %0d cycles tick=%b want 3 cycles tick=1", n, tick_o[0]);
    else n_pass++;
    for (int h = 0; h < 2; h++) begin
      n = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        cycle(); n++; got = tick_o[0];
      end
      n_tot++;
      if (n != 2) $display("FAIL reload_new_half%0d: got %0d cycles want 2", h, n);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int n;
    logic got;
    set_load(3, 4); cycle(); load_i = '0;
    cycle();
    en_i[3] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(); got = tick_o[3];
    end
    cycle();
    set_load(3, 2); cycle(); load_i = '0;
    cycle(); cycle();
    set_load(3, 9); cycle(); load_i = '0;
    n_tot++;
    if (tick_o[3] !== 1'b1 || pend_o[3] !== 1'b1)
      $display("FAIL collide_boundary: got tick=%b pend=%b want tick=1 pend=1", tick_o[3], pend_o[3]);
    else n_pass++;
    n_tot++;
    if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
      $display("FAIL collide_model: got %b/%b/%b want %b/%b/%b", clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
    else n_pass++;
    n = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(); n++; got = tick_o[3];
    end
    n_tot++;
    if (n != 3 || pend_o[3] !== 1'b0)
      $display("FAIL collide_second_apply: got %0d cycles pend=%b want 3 cycles pend=0", n, pend_o[3]);
    else n_pass++;
    n = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(); n++; got = tick_o[3];
    end
    n_tot++;
    if (n != 10) $display("FAIL collide_new_half: got %0d cycles want 10", n);
    else n_pass++;
  endtask

`ifdef CLK_DIV_DUTY_EN
  task automatic test_duty();
    int highs;
    en_i[1] = 1'b0; cycle();
    set_load(1, 3); hi_i[1*DIV_W +: DIV_W] = DIV_W'(1);
    cycle(); load_i = '0;
    cycle();
    en_i[1] = 1'b1;
    highs = 0;
    for (int i = 0; i < 36; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL duty_run cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
      highs += int'(clk_o[1]);
    end
    n_tot++;
    if (highs != 12) $display("FAIL duty_high_count: got %0d want 12", highs);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 19) == 0) en_i[k] = ~en_i[k];
        load_i[k] = ($urandom_range(0, 11) == 0);
        if (load_i[k]) begin
          div_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
`ifdef CLK_DIV_DUTY_EN
          hi_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
`endif
        end
      end
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL random cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
    end
    load_i = '0;
  endtask

  task automatic test_async_reset();
    int first;
    en_i = '1;
    set_load(3, 50); cycle(); load_i = '0;
    cycle();
    n_tot++;
    if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
      $display("FAIL areset_pre: got %b/%b/%b want %b/%b/%b", clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({clk_o, tick_o, pend_o} !== '0)
      $display("FAIL areset_immediate: clk/tick/pend got %b/%b/%b want all 0", clk_o, tick_o, pend_o);
    else n_pass++;
    model_reset();
    en_i = '0;
    @(negedge clk); rst_n = 1'b1;
    cycle();
    en_i[0] = 1'b1;
    first = 0;
    for (int i = 1; i <= 4000 && first == 0; i++) begin
      cycle();
      n_tot++;
      if ({clk_o, tick_o, pend_o} !== {m_clk, m_tick, m_pend})
        $display("FAIL areset_after cyc%0d: got %b/%b/%b want %b/%b/%b", i, clk_o, tick_o, pend_o, m_clk, m_tick, m_pend);
      else n_pass++;
      if (clk_o[0]) first = i;
    end
    n_tot++;
    if (first != DEFAULT_DIV + 1)
      $display("FAIL areset_default_div: got %0d cycles want %0d", first, DEFAULT_DIV + 1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_divide();
    test_div2();
    test_mid_reload();
    test_collision();
`ifdef CLK_DIV_DUTY_EN
    test_duty();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
